vga_frame_controller: RTL and testbench
=======================================

Name: vga_frame_controller

Overview:
- Parametrised successor to the board's VGA controller. Owns one single-port framebuffer RAM and time-shares it between two users: the CPU, which writes processed pixels, and the VGA scan-out.
- Generates VGA timing internally from one system clock using a pixel clock-enable. No derived clocks and no gated clocks.
- Keeps hSync/vSync running in every state, so the monitor never loses lock.
- Sits between the CPU wrapper and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- PIX_DIV, 4, clk cycles per pixel (4 gives 25 MHz from 100 MHz); must be ≥2
- COLOR_BITS, 12, framebuffer word width ({R,G,B}, equal thirds)
- ADDR_WIDTH, 19, framebuffer address width; must be ≥ clog2(H_ACTIVE*V_ACTIVE)
- SYNC_POL, 0, level of hSync/vSync during their sync pulse (0 = active-low)

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- start  in  1  1-cycle pulse: request a processing pass
- proc_we  in  1  CPU write strobe
- proc_addr  in  ADDR_WIDTH  CPU pixel address
- proc_wdata  in  COLOR_BITS  CPU pixel data
- proc_ready  out  1  high while CPU owns the framebuffer (PROCESS)
- done  out  1  1-cycle pulse when the pass completes
- fb_addr  out  ADDR_WIDTH  framebuffer address
- fb_we  out  1  framebuffer write enable
- fb_wdata  out  COLOR_BITS  framebuffer write data
- fb_rdata  in  COLOR_BITS  framebuffer read data, valid 1 clk after fb_addr
- hSync  out  1  horizontal sync
- vSync  out  1  vertical sync
- vga_rgb  out  COLOR_BITS  pixel colour, zero outside the active area
- state_o  out  2  current FSM state, for LEDs
- frame_tick  out  1  1-cycle pulse at each frame end

Behaviour:
- Reset state (reset=0): all counters 0, FSM=IDLE. Outputs: proc_ready=0, done=0, fb_we=0, fb_addr=0, fb_wdata=0, vga_rgb=0, frame_tick=0, hSync=vSync=!SYNC_POL.
- Reset taken mid-frame or mid-pass aborts immediately. No done pulse is produced.
- Pixel enable: pix_en is high for one clk every PIX_DIV clk cycles. h_cnt/v_cnt advance only on pix_en.
  - h_cnt wraps at H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP).
  - v_cnt increments on h_cnt wrap and wraps at V_TOTAL-1.
- Sync: hSync=SYNC_POL when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. vSync uses the same rule on v_cnt.
- frame_tick pulses on the pix_en where both counters wrap.
- Scan address is incremental, no multiplier. It is cleared at frame end and incremented on each pix_en with an active pixel.
- Pipeline: registered address → RAM (1 clk) → registered colour.
  - active, hSync and vSync are delayed by the same 2 clk stages.
  - Net latency from the counter update to the pins is 2 clk, constant across states.
- FSM states: IDLE (00), PROCESS (01), DISPLAY (10).
  - IDLE: scan-out active (displays the initial image).
  - start sets a pending flag. The transition to PROCESS happens on the next frame_tick (tear-free).
  - start received while already pending is absorbed (idempotent).
  - PROCESS:
    - fb_addr=proc_addr, fb_we=proc_we and (proc_addr < PIXEL_COUNT), fb_wdata=proc_wdata.
    - proc_ready=1; vga_rgb forced 0; syncs continue.
    - Writes to addr ≥ PIXEL_COUNT are dropped.
  - Completion: a qualifying write to PIXEL_COUNT-1 → done=1 for the following clk, FSM → DISPLAY, proc_ready=0 in the same clk.
  - DISPLAY: same as IDLE; start → PROCESS at the next frame_tick.
- Ownership rules:
  - proc_we outside PROCESS is ignored; fb_we stays 0.
  - start arriving in PROCESS is ignored.
  - start arriving in the same clk as frame_tick takes effect at the following frame_tick.
- Width rules:
  - h_cnt/v_cnt are sized with clog2(total).
  - PIXEL_COUNT=H_ACTIVE*V_ACTIVE is a localparam.
  - Address comparisons are zero-extended to ADDR_WIDTH.

Decomposition:
- Package vga_pkg: state encoding localparams (ST_IDLE, ST_PROCESS, ST_DISPLAY) and the default 640x480@60 timing constants.
- Sub-module vga_timing: pix_en divider, h/v counters, sync, active, frame_tick. Parametrised by the timing parameters.
- Top level: FSM, framebuffer arbitration mux, scan-address counter, output pipeline.

Test Plan:
- Reset low then released, idle 2 frames → hSync period 800 pixels × PIX_DIV = 3200 clk; hSync low for 384 clk; vSync low for 2 lines; state_o=00.
- start at mid-frame → state_o stays 00 until the next frame_tick, then becomes 01 with proc_ready=1 in the same clk; vga_rgb=0 throughout PROCESS.
- In PROCESS, write addr 5 ← 12'hF00, then addr 307199 ← 12'h0F0 → fb_we seen twice; done pulses 1 clk after the second write; state_o=10.
- DISPLAY frame: pixel (5,0) → vga_rgb=12'hF00; pixel (639,479) → 12'h0F0; both appear 2 clk after the counter reaches the pixel; blanking region shows 0.
- proc_we in DISPLAY, and a PROCESS write to addr 307200 → fb_we stays 0; no done; FSM unchanged.
- Reset asserted mid-PROCESS → asynchronously state_o=00, proc_ready=0, fb_we=0, syncs at idle level; no done pulse after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared state encoding and default 640x480@60 timing for the VGA frame controller.
package vga_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PROCESS = 2'b01;
    localparam logic [1:0] ST_DISPLAY = 2'b10;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StProcess = ST_PROCESS,
        StDisplay = ST_DISPLAY
    } state_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_PIX_DIV  = 4;

endpackage

// File: rtl/vga_frame_controller_if.sv
// Single-port framebuffer RAM bus; the controller is master, the RAM is slave.
interface vga_frame_controller_if #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned COLOR_BITS = 12
);
    logic [ADDR_WIDTH-1:0] fb_addr;
    logic                  fb_we;
    logic [COLOR_BITS-1:0] fb_wdata;
    logic [COLOR_BITS-1:0] fb_rdata;

    modport master (output fb_addr, output fb_we, output fb_wdata, input fb_rdata);
    modport slave  (input fb_addr, input fb_we, input fb_wdata, output fb_rdata);
endinterface

// File: rtl/vga_timing.sv
// Pixel clock-enable divider and h/v raster counters with combinational sync/active decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_en_o,
    output logic active_o,
    output logic h_sync_o,
    output logic v_sync_o,
    output logic frame_tick_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);
    localparam int unsigned DIVW    = $clog2(PIX_DIV);

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PIX_DIV - 1);
    localparam logic [HCW-1:0]  H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0]  V_LAST   = VCW'(V_TOTAL - 1);

    logic [DIVW-1:0] div_q, div_d;
    logic [HCW-1:0]  h_cnt_q, h_cnt_d;
    logic [VCW-1:0]  v_cnt_q, v_cnt_d;
    logic            h_wrap, v_wrap, in_h_sync, in_v_sync;

    assign pix_en_o = (div_q == DIV_LAST);
    assign h_wrap   = (h_cnt_q == H_LAST);
    assign v_wrap   = (v_cnt_q == V_LAST);

    always_comb begin
        div_d   = pix_en_o ? '0 : div_q + 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_o) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Compare at 32 bits so a sync end equal to the total still fits.
    assign in_h_sync = (32'(h_cnt_q) >= H_ACTIVE + H_FP)
                    && (32'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    assign in_v_sync = (32'(v_cnt_q) >= V_ACTIVE + V_FP)
                    && (32'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);

    assign h_sync_o     = in_h_sync ? SYNC_POL : ~SYNC_POL;
    assign v_sync_o     = in_v_sync ? SYNC_POL : ~SYNC_POL;
    assign active_o     = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    assign frame_tick_o = pix_en_o && h_wrap && v_wrap;

endmodule

// File: rtl/vga_frame_controller.sv
// VGA scan-out plus CPU framebuffer ownership FSM sharing one single-port RAM.
module vga_frame_controller
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned PIX_DIV    = DEF_PIX_DIV,
    parameter int unsigned COLOR_BITS = 12,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter bit          SYNC_POL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  proc_we,
    input  logic [ADDR_WIDTH-1:0] proc_addr,
    input  logic [COLOR_BITS-1:0] proc_wdata,
    output logic                  proc_ready,
    output logic                  done,
    vga_frame_controller_if.master fb,
    output logic                  hSync,
    output logic                  vSync,
    output logic [COLOR_BITS-1:0] vga_rgb,
    output logic [1:0]            state_o,
    output logic                  frame_tick
);

    localparam int unsigned           PIXEL_COUNT = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_WIDTH-1:0] PIX_LAST    = ADDR_WIDTH'(PIXEL_COUNT - 1);

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] scan_q, scan_d;
    logic                  valid1_q;
    logic [1:0]            hs_q, vs_q;
    logic [COLOR_BITS-1:0] rgb_q;
    logic                  pix_en, active, h_sync, v_sync;
    logic                  in_process, wr_ok;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PIX_DIV  (PIX_DIV),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk_i        (clk),
        .rst_ni       (reset),
        .pix_en_o     (pix_en),
        .active_o     (active),
        .h_sync_o     (h_sync),
        .v_sync_o     (v_sync),
        .frame_tick_o (frame_tick)
    );

    assign in_process = (state_q == StProcess);
    assign wr_ok      = in_process && proc_we && (proc_addr <= PIX_LAST);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle, StDisplay: begin
                // pending_q is registered, so a start coinciding with frame_tick waits a frame.
                if (frame_tick && pending_q) begin
                    state_d   = StProcess;
                    pending_d = 1'b0;
                end else if (start) begin
                    pending_d = 1'b1;
                end
            end
            StProcess: begin
                if (wr_ok && (proc_addr == PIX_LAST)) begin
                    state_d = StDisplay;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        scan_d = scan_q;
        if (frame_tick) begin
            scan_d = '0;
        end else if (pix_en && active) begin
            scan_d = scan_q + 1'b1;
        end
    end

    always_comb begin
        fb.fb_we    = wr_ok;
        fb.fb_addr  = scan_q;
        fb.fb_wdata = '0;
        if (in_process) begin
            fb.fb_addr  = proc_addr;
            fb.fb_wdata = proc_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            scan_q    <= '0;
            valid1_q  <= 1'b0;
            hs_q      <= {2{~SYNC_POL}};
            vs_q      <= {2{~SYNC_POL}};
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            scan_q    <= scan_d;
            // Qualify with ownership at address time so a CPU-address read never reaches the pins.
            valid1_q  <= active && !in_process;
            hs_q      <= {hs_q[0], h_sync};
            vs_q      <= {vs_q[0], v_sync};
            rgb_q     <= valid1_q ? fb.fb_rdata : '0;
        end
    end

    assign hSync      = hs_q[1];
    assign vSync      = vs_q[1];
    assign vga_rgb    = rgb_q;
    assign state_o    = state_q;
    assign proc_ready = in_process;
    assign done       = done_q;

endmodule

// File: tb/tb_vga_frame_controller.sv
// Directed bench on a shrunken 8x4 raster (15x8 total, 4 clk/pixel) with a behavioural RAM.
module tb_vga_frame_controller;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int unsigned PD = 4, CB = 12, AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          proc_we = 1'b0;
    logic [AW-1:0] proc_addr = '0;
    logic [CB-1:0] proc_wdata = '0;
    logic          proc_ready, done, hSync, vSync, frame_tick;
    logic [CB-1:0] vga_rgb;
    logic [1:0]    state_o;

    logic          load_mem = 1'b1;
    logic [CB-1:0] mem [0:63];
    logic [CB-1:0] rdata_q;
    int            we_seen = 0;
    int            checks = 0;
    int            passed = 0;

    vga_frame_controller_if #(.ADDR_WIDTH(AW), .COLOR_BITS(CB)) fb_bus ();

    vga_frame_controller #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .PIX_DIV (PD), .COLOR_BITS (CB), .ADDR_WIDTH (AW), .SYNC_POL (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .proc_we    (proc_we),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_ready (proc_ready),
        .done       (done),
        .fb         (fb_bus),
        .hSync      (hSync),
        .vSync      (vSync),
        .vga_rgb    (vga_rgb),
        .state_o    (state_o),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, initial image mem[i] = i+1.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= CB'(i + 1);
        end else if (fb_bus.fb_we) begin
            mem[fb_bus.fb_addr] <= fb_bus.fb_wdata;
        end
        rdata_q <= mem[fb_bus.fb_addr];
        if (fb_bus.fb_we) we_seen <= we_seen + 1;
    end
    assign fb_bus.fb_rdata = rdata_q;

    // Returns at the negedge on which frame_tick is high.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pixel index p = y*15+x appears on the pins for negedges p*4+3 .. p*4+6 after frame_tick.
    task automatic grab_pixel(input int p, output logic [CB-1:0] first_v,
                              output logic [CB-1:0] last_v, output bit ok);
        first_v = 'x;
        last_v  = 'x;
        wait_tick(ok);
        for (int k = 1; k <= p * 4 + 6; k++) begin
            @(negedge clk);
            if (k == p * 4 + 3) first_v = vga_rgb;
            if (k == p * 4 + 6) last_v = vga_rgb;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (state_o !== 2'b00) $display("FAIL reset_state got=%0h exp=0", state_o); else passed++;
        checks++; if (proc_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", proc_ready); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        checks++; if (fb_bus.fb_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", fb_bus.fb_we); else passed++;
        checks++; if (fb_bus.fb_addr !== '0) $display("FAIL reset_addr got=%0h exp=0", fb_bus.fb_addr); else passed++;
        checks++; if (fb_bus.fb_wdata !== '0) $display("FAIL reset_wdata got=%0h exp=0", fb_bus.fb_wdata); else passed++;
        checks++; if (vga_rgb !== '0) $display("FAIL reset_rgb got=%0h exp=0", vga_rgb); else passed++;
        checks++; if (frame_tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", frame_tick); else passed++;
        checks++; if ({hSync, vSync} !== 2'b11) $display("FAIL reset_sync got=%b%b exp=11", hSync, vSync); else passed++;
        load_mem = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_sync_timing();
        int hf[$], hr[$], vf[$], vr[$], ft[$];
        int hper, hlow, vlow, fper;
        logic hp, vp;
        bit idle_ok = 1'b1;
        hp = hSync;
        vp = vSync;
        for (int c = 1; c <= 1200; c++) begin
            @(negedge clk);
            if (hp && !hSync) hf.push_back(c);
            if (!hp && hSync && hf.size() > 0) hr.push_back(c);
            if (vp && !vSync) vf.push_back(c);
            if (!vp && vSync && vf.size() > 0) vr.push_back(c);
            if (frame_tick) ft.push_back(c);
            if (state_o !== 2'b00) idle_ok = 1'b0;
            hp = hSync;
            vp = vSync;
        end
        hper = (hf.size() >= 2) ? hf[1] - hf[0] : -1;
        hlow = (hr.size() >= 1) ? hr[0] - hf[0] : -1;
        vlow = (vr.size() >= 1) ? vr[0] - vf[0] : -1;
        fper = (ft.size() >= 2) ? ft[1] - ft[0] : -1;
        checks++; if (hper != 60) $display("FAIL hsync_period got=%0d exp=60", hper); else passed++;
        checks++; if (hlow != 12) $display("FAIL hsync_low got=%0d exp=12", hlow); else passed++;
        checks++; if (vlow != 120) $display("FAIL vsync_low got=%0d exp=120", vlow); else passed++;
        checks++; if (fper != 480) $display("FAIL frame_period got=%0d exp=480", fper); else passed++;
        checks++; if (!idle_ok) $display("FAIL idle_state got=nonzero exp=0"); else passed++;
    endtask

    task automatic test_idle_image();
        logic [CB-1:0] f, l;
        logic          h42, h43;
        bit            ok;
        grab_pixel(0, f, l, ok);
        checks++; if (!ok || f !== 12'd1 || l !== 12'd1) $display("FAIL idle_px0 got=%0h/%0h exp=1", f, l); else passed++;
        grab_pixel(33, f, l, ok);
        checks++; if (!ok || f !== 12'd20 || l !== 12'd20) $display("FAIL idle_px3_2 got=%0h/%0h exp=14", f, l); else passed++;
        grab_pixel(24, f, l, ok);
        checks++; if (!ok || f !== '0 || l !== '0) $display("FAIL idle_blank got=%0h/%0h exp=0", f, l); else passed++;
        // h_cnt reaches the sync start 40 clk after the wrap; pins follow 2 clk later.
        wait_tick(ok);
        h42 = 1'bx;
        h43 = 1'bx;
        for (int k = 1; k <= 43; k++) begin
            @(negedge clk);
            if (k == 42) h42 = hSync;
            if (k == 43) h43 = hSync;
        end
        checks++; if (!ok || {h42, h43} !== 2'b10) $display("FAIL hsync_latency got=%b%b exp=10", h42, h43); else passed++;
    endtask

    task automatic test_start_mid_frame();
        bit ok, found = 1'b0, stayed = 1'b1;
        wait_tick(ok);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (state_o !== 2'b00) stayed = 1'b0;
            if (frame_tick) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!ok || !found) $display("FAIL pending_tick got=timeout exp=frame_tick"); else passed++;
        checks++; if (!stayed) $display("FAIL pending_hold got=left_idle exp=00"); else passed++;
        @(negedge clk);
        checks++; if (state_o !== 2'b01) $display("FAIL enter_process got=%0h exp=1", state_o); else passed++;
        checks++; if (proc_ready !== 1'b1) $display("FAIL proc_ready got=%b exp=1", proc_ready); else passed++;
    endtask

    task automatic test_process();
        bit rgb_zero = 1'b1, ready_hi = 1'b1, quiet = 1'b1;
        int we0;
        for (int i = 0; i < 500; i++) begin
            start = (i == 50);
            @(negedge clk);
            if (vga_rgb !== '0) rgb_zero = 1'b0;
            if (proc_ready !== 1'b1) ready_hi = 1'b0;
            if (fb_bus.fb_we !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        start = 1'b0;
        checks++; if (!rgb_zero) $display("FAIL process_rgb got=nonzero exp=0"); else passed++;
        checks++; if (!ready_hi) $display("FAIL process_ready got=dropped exp=1"); else passed++;
        checks++; if (!quiet) $display("FAIL process_idle_bus got=active exp=quiet"); else passed++;
        we0 = we_seen;
        proc_we = 1'b1; proc_addr = 6'd5; proc_wdata = 12'hF00;
        #1;
        checks++; if ({fb_bus.fb_we, fb_bus.fb_addr, fb_bus.fb_wdata} !== {1'b1, 6'd5, 12'hF00})
            $display("FAIL write5 got=%b/%0h/%0h exp=1/5/f00", fb_bus.fb_we, fb_bus.fb_addr, fb_bus.fb_wdata);
        else passed++;
        @(negedge clk);
        proc_addr = 6'd32; proc_wdata = 12'hABC;
        #1;
        checks++; if (fb_bus.fb_we !== 1'b0) $display("FAIL write_oob32 got=%b exp=0", fb_bus.fb_we); else passed++;
        @(negedge clk);
        proc_addr = 6'd63;
        #1;
        checks++; if (fb_bus.fb_we !== 1'b0) $display("FAIL write_oob63 got=%b exp=0", fb_bus.fb_we); else passed++;
        @(negedge clk);
        checks++; if ({done, state_o} !== 3'b001) $display("FAIL oob_no_done got=%b/%0h exp=0/1", done, state_o); else passed++;
        proc_addr = 6'd31; proc_wdata = 12'h0F0;
        #1;
        checks++; if (fb_bus.fb_we !== 1'b1) $display("FAIL write_last got=%b exp=1", fb_bus.fb_we); else passed++;
        @(negedge clk);
        proc_we = 1'b0;
        checks++; if (done !== 1'b1) $display("FAIL done_pulse got=%b exp=1", done); else passed++;
        checks++; if (state_o !== 2'b10) $display("FAIL enter_display got=%0h exp=2", state_o); else passed++;
        checks++; if (proc_ready !== 1'b0) $display("FAIL ready_drop got=%b exp=0", proc_ready); else passed++;
        checks++; if (we_seen - we0 != 2) $display("FAIL we_count got=%0d exp=2", we_seen - we0); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL done_width got=%b exp=0", done); else passed++;
    endtask

    task automatic test_display();
        logic [CB-1:0] f, l;
        bit            ok;
        wait_tick(ok);
        @(negedge clk);
        checks++; if (!ok || state_o !== 2'b10) $display("FAIL start_in_process got=%0h exp=2", state_o); else passed++;
        grab_pixel(5, f, l, ok);
        checks++; if (!ok || f !== 12'hF00 || l !== 12'hF00) $display("FAIL disp_px5 got=%0h/%0h exp=f00", f, l); else passed++;
        grab_pixel(52, f, l, ok);
        checks++; if (!ok || f !== 12'h0F0 || l !== 12'h0F0) $display("FAIL disp_last got=%0h/%0h exp=0f0", f, l); else passed++;
        grab_pixel(15, f, l, ok);
        checks++; if (!ok || f !== 12'd9 || l !== 12'd9) $display("FAIL disp_px0_1 got=%0h/%0h exp=9", f, l); else passed++;
        grab_pixel(8, f, l, ok);
        checks++; if (!ok || f !== '0 || l !== '0) $display("FAIL disp_blank got=%0h/%0h exp=0", f, l); else passed++;
        @(negedge clk);
        proc_we = 1'b1; proc_addr = 6'd3; proc_wdata = 12'hFFF;
        #1;
        checks++; if (fb_bus.fb_we !== 1'b0) $display("FAIL display_we got=%b exp=0", fb_bus.fb_we); else passed++;
        @(negedge clk);
        proc_we = 1'b0;
        checks++; if ({done, state_o} !== 3'b010) $display("FAIL display_hold got=%b/%0h exp=0/2", done, state_o); else passed++;
        grab_pixel(3, f, l, ok);
        checks++; if (!ok || f !== 12'd4) $display("FAIL display_write_dropped got=%0h exp=4", f); else passed++;
    endtask

    task automatic test_start_on_tick();
        bit ok;
        wait_tick(ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (!ok || state_o !== 2'b10) $display("FAIL start_on_tick got=%0h exp=2", state_o); else passed++;
        wait_tick(ok);
        @(negedge clk);
        checks++; if (!ok || state_o !== 2'b01) $display("FAIL start_next_tick got=%0h exp=1", state_o); else passed++;
    endtask

    task automatic test_reset_mid_process();
        bit no_done = 1'b1, idle = 1'b1;
        @(negedge clk);
        proc_we = 1'b1; proc_addr = 6'd3; proc_wdata = 12'h123;
        #1;
        reset = 1'b0;
        #1;
        checks++; if (state_o !== 2'b00) $display("FAIL async_state got=%0h exp=0", state_o); else passed++;
        checks++; if (proc_ready !== 1'b0) $display("FAIL async_ready got=%b exp=0", proc_ready); else passed++;
        checks++; if (fb_bus.fb_we !== 1'b0) $display("FAIL async_we got=%b exp=0", fb_bus.fb_we); else passed++;
        checks++; if ({hSync, vSync} !== 2'b11) $display("FAIL async_sync got=%b%b exp=11", hSync, vSync); else passed++;
        proc_we = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done !== 1'b0) no_done = 1'b0;
            if (state_o !== 2'b00) idle = 1'b0;
        end
        checks++; if (!no_done) $display("FAIL reset_no_done got=1 exp=0"); else passed++;
        checks++; if (!idle) $display("FAIL reset_stays_idle got=nonzero exp=0"); else passed++;
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_idle_image();
        test_start_mid_frame();
        test_process();
        test_display();
        test_start_on_tick();
        test_reset_mid_process();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
